// File: rtl/mul_pipe.sv
// mul_pipe: parametrised, fully pipelined integer multiplier for the MDU.
//
// Computes MUL / MULH / MULHSU / MULHU on two XLEN-bit operands and returns
// the selected XLEN-bit half of the exact 2*XLEN-bit product. The pipeline
// is STAGES deep (1..4). Each op carries an opaque tag. Both sides use a
// valid/ready handshake, and a flush kills every op in flight.
//
// Optional feature: define MUL_PIPE_WORD_EN (XLEN must be 64) to add in_word.
// With in_word=1 the op is MULW: the low 32 bits of in_a[31:0]*in_b[31:0],
// sign-extended to 64 bits. in_funct3 must then be 000.
//
// Ports:
//   clk        in   1     clock, rising edge
//   reset      in   1     synchronous, active-low reset
//   flush      in   1     kill all in-flight ops at the next edge
//   in_valid   in   1     operation offered
//   in_ready   out  1     pipe accepts this cycle
//   in_a       in   XLEN  source A
//   in_b       in   XLEN  source B
//   in_funct3  in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 1xx = MUL
//   in_tag     in   TAGW  tag carried with the op
//   in_word    in   1     MULW select (only with MUL_PIPE_WORD_EN)
//   out_valid  out  1     result available
//   out_ready  in   1     consumer accepts
//   out_result out  XLEN  selected product half
//   out_tag    out  TAGW  tag of the result

module mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic [2:0]      in_funct3,
    input  logic [TAGW-1:0] in_tag,
`ifdef MUL_PIPE_WORD_EN
    input  logic            in_word,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [TAGW-1:0] out_tag
);

    localparam int W2 = 2 * XLEN;
    localparam int LW = XLEN - 1;   // width of the operand magnitude part

`ifdef MUL_PIPE_WORD_EN
    localparam int OPW = 4;         // {word, funct3}
`else
    localparam int OPW = 3;         // funct3
`endif

    logic [OPW-1:0] in_op;
`ifdef MUL_PIPE_WORD_EN
    assign in_op = {in_word, in_funct3};
`else
    assign in_op = in_funct3;
`endif

    // Select the result half from the full product. MULW takes the low word
    // and sign-extends it; the low product word does not depend on the upper
    // operand bits, so the partial products need no special handling.
    function automatic logic [XLEN-1:0] pick(input logic [W2-1:0] p,
                                             input logic [OPW-1:0] op);
        logic hi;
        hi = ~op[2] & (op[1:0] != 2'b00);
`ifdef MUL_PIPE_WORD_EN
        if (op[3]) return {{(XLEN-32){p[31]}}, p[31:0]};
`endif
        return hi ? p[W2-1:XLEN] : p[XLEN-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Partial products of A=(am,a_lo), B=(bm,b_lo).
    //   terms[0] = a_lo*b_lo
    //   terms[1] = a_lo*bm << LW   (negated when B is signed)
    //   terms[2] = am*b_lo << LW   (negated when A is signed)
    //   terms[3] = am*bm << 2*LW   (negated when exactly one side is signed)
    //              plus the +1 of each two's-complement negation above
    // ------------------------------------------------------------------
    logic [W2-1:0] terms_c [4];
    logic [LW-1:0] a_lo, b_lo;
    logic          am, bm, sa, sb;
    logic [W2-1:0] pa_raw, pb_raw, pm_val;

    // NOTE: every combinational output gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        a_lo   = in_a[LW-1:0];
        b_lo   = in_b[LW-1:0];
        am     = in_a[XLEN-1];
        bm     = in_b[XLEN-1];
        sa     = (in_funct3 == 3'b001) || (in_funct3 == 3'b010);
        sb     = (in_funct3 == 3'b001);
        pa_raw = bm ? (W2'(a_lo) << LW) : '0;
        pb_raw = am ? (W2'(b_lo) << LW) : '0;
        pm_val = '0;
        if (am & bm) pm_val[W2-1:W2-2] = (sa ^ sb) ? 2'b11 : 2'b01;
        terms_c[0] = W2'(a_lo) * W2'(b_lo);
        terms_c[1] = sb ? ~pa_raw : pa_raw;
        terms_c[2] = sa ? ~pb_raw : pb_raw;
        terms_c[3] = pm_val + W2'(sa) + W2'(sb);
    end

    // ------------------------------------------------------------------
    // Handshake: stage k advances when empty or when stage k+1 advances.
    // ld[k] marks a real op moving into stage k this cycle.
    // ------------------------------------------------------------------
    logic [STAGES:1] valid_q, adv, ld;
    logic            accept, chain;
    logic [TAGW-1:0] tag_q [1:STAGES];
    logic [XLEN-1:0] res_q, final_d;

    always_comb begin
        adv   = '0;
        ld    = '0;
        chain = ~valid_q[STAGES] | out_ready;
        adv[STAGES] = chain;
        for (int k = STAGES - 1; k >= 1; k--) begin
            chain  = ~valid_q[k] | chain;
            adv[k] = chain;
        end
        // Reset and flush both block acceptance; a free or moving stage 1
        // lets a new op in, which also collapses bubbles.
        in_ready = reset & ~flush & (~valid_q[1] | adv[1]);
        accept   = in_valid & in_ready;
        ld[1]    = accept;
        for (int k = 2; k <= STAGES; k++) ld[k] = adv[k] & valid_q[k-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            for (int k = 1; k <= STAGES; k++) tag_q[k] <= '0;
        end else begin
            if (flush) begin
                valid_q <= '0;
            end else begin
                if (adv[1]) valid_q[1] <= accept;
                for (int k = 2; k <= STAGES; k++)
                    if (adv[k]) valid_q[k] <= valid_q[k-1];
            end
            if (ld[1]) tag_q[1] <= in_tag;
            for (int k = 2; k <= STAGES; k++)
                if (ld[k]) tag_q[k] <= tag_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Datapath stages. Stage 1 holds the four terms, stage 2 two pair sums,
    // stage 3 the full product; the last stage always holds the chosen half.
    // ------------------------------------------------------------------
    // NOTE: intermediate data registers are not reset; they are only read
    // behind a set valid bit. Only the visible output registers reset.
    if (STAGES == 1) begin : g_s1
        assign final_d = pick(terms_c[0] + terms_c[1] + terms_c[2] + terms_c[3], in_op);
    end else begin : g_deep
        logic [W2-1:0]  t1_q [4];
        logic [OPW-1:0] op1_q;

        always_ff @(posedge clk) begin
            if (ld[1]) begin
                for (int i = 0; i < 4; i++) t1_q[i] <= terms_c[i];
                op1_q <= in_op;
            end
        end

        if (STAGES == 2) begin : g_s2
            assign final_d = pick(t1_q[0] + t1_q[1] + t1_q[2] + t1_q[3], op1_q);
        end else begin : g_s3
            logic [W2-1:0]  p2_q [2];
            logic [OPW-1:0] op2_q;

            always_ff @(posedge clk) begin
                if (ld[2]) begin
                    p2_q[0] <= t1_q[0] + t1_q[1];
                    p2_q[1] <= t1_q[2] + t1_q[3];
                    op2_q   <= op1_q;
                end
            end

            if (STAGES == 3) begin : g_end3
                assign final_d = pick(p2_q[0] + p2_q[1], op2_q);
            end else begin : g_s4
                logic [W2-1:0]  p3_q;
                logic [OPW-1:0] op3_q;

                always_ff @(posedge clk) begin
                    if (ld[3]) begin
                        p3_q  <= p2_q[0] + p2_q[1];
                        op3_q <= op2_q;
                    end
                end

                assign final_d = pick(p3_q, op3_q);
            end
        end
    end

    // The output register only loads with a real op, so it holds steady
    // under backpressure and stays zero after reset until the first result.
    always_ff @(posedge clk) begin
        if (!reset) res_q <= '0;
        else if (ld[STAGES]) res_q <= final_d;
    end

    assign out_valid  = valid_q[STAGES];
    assign out_result = res_q;
    assign out_tag    = tag_q[STAGES];

endmodule
